// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage helpers: the divider FSM
// state encoding and the default operand width with its iteration counter width.
package mips_pkg;

  localparam int DIV_LEN   = 32;
  localparam int DIV_CNT_W = $clog2(DIV_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then trial-subtract the divisor with a single LEN+1-bit
// subtractor whose MSB is the borrow.
module div_step #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] rem,
  input  logic           dvd_msb,
  input  logic [LEN-1:0] dvs,
  output logic [LEN-1:0] rem_next,
  output logic           q_bit
);

  logic [LEN-1:0] shifted;
  logic [LEN:0]   diff;

  // The shifted-out top remainder bit is always zero here, since the partial
  // remainder after j iterations is below 2^j; borrow clear means rem >= dvs.
  always_comb begin
    shifted  = {rem[LEN-2:0], dvd_msb};
    diff     = {1'b0, shifted} - {1'b0, dvs};
    q_bit    = ~diff[LEN];
    rem_next = diff[LEN] ? shifted : diff[LEN-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage. Operands are converted to
// magnitudes on acceptance, one quotient bit is resolved per clock, and the
// signs are reapplied in a final fix-up cycle that also registers the results.
module div_unit
  import mips_pkg::*;
#(
  parameter int LEN = DIV_LEN
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic           i_signed,
  input  logic [LEN-1:0] i_dividend,
  input  logic [LEN-1:0] i_divisor,
  output logic [LEN-1:0] o_quotient,
  output logic [LEN-1:0] o_remainder,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_div_by_zero
);

  localparam int CNT_W = $clog2(LEN + 1);

  div_state_t     state;
  logic [CNT_W-1:0] count;
  logic [LEN-1:0] rem;
  logic [LEN-1:0] dvd;
  logic [LEN-1:0] dvs;
  logic           neg_q;
  logic           neg_r;
  logic           zero_div;
  logic [LEN-1:0] quotient;
  logic [LEN-1:0] remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  logic [LEN-1:0] dividend_abs;
  logic [LEN-1:0] divisor_abs;
  logic [LEN-1:0] rem_next;
  logic           q_bit;

  // Magnitudes of the incoming operands; only negated in signed mode.
  always_comb begin
    dividend_abs = (i_signed && i_dividend[LEN-1]) ? -i_dividend : i_dividend;
    divisor_abs  = (i_signed && i_divisor[LEN-1])  ? -i_divisor  : i_divisor;
  end

  div_step #(
    .LEN(LEN)
  ) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[LEN-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Divider FSM: accept in IDLE, iterate LEN times in RUN, then sign-correct
  // and publish in FIX. The dividend register doubles as the quotient
  // accumulator, and on divide-by-zero it keeps the raw dividend for HI.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            neg_q    <= i_signed & (i_dividend[LEN-1] ^ i_divisor[LEN-1]);
            neg_r    <= i_signed & i_dividend[LEN-1];
            zero_div <= (i_divisor == '0);
            dvd      <= (i_divisor == '0) ? i_dividend : dividend_abs;
            dvs      <= divisor_abs;
            rem      <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= (i_divisor == '0) ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          rem   <= rem_next;
          dvd   <= {dvd[LEN-2:0], q_bit};
          count <= count + CNT_W'(1);
          if (count == CNT_W'(LEN - 1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dvd;
          end else begin
            quotient  <= neg_q ? -dvd : dvd;
            remainder <= neg_r ? -rem : rem;
          end
          div_by_zero <= zero_div;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_quotient    = quotient;
  assign o_remainder   = remainder;
  assign o_busy        = busy;
  assign o_done        = done;
  assign o_div_by_zero = div_by_zero;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (LEN=32): unsigned/signed results, latency,
// overflow, divide-by-zero, ignored starts, back-to-back start and reset abort.
module tb_div_unit;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_busy;
  logic        o_done;
  logic        o_div_by_zero;

  int assertions;
  int failures;
  int edges;
  int busy_cycles;
  int saw_done;

  div_unit #(
    .LEN(32)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_signed      (i_signed),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero)
  );

  // Free-running 10 ns clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a negedge: holds i_start for the next rising edge, then
  // returns at the following negedge with operands scrambled.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s);
    i_start    = 1'b1;
    i_signed   = s;
    i_dividend = a;
    i_divisor  = b;
    @(negedge i_clk);
    i_start    = 1'b0;
    i_signed   = ~s;
    i_dividend = 32'hDEAD_BEEF;
    i_divisor  = 32'h0000_0000;
  endtask

  // Counts edges from the accepting edge until o_done, bounded.
  task automatic waitDone(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = o_busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      n_edges++;
      if (o_done) break;
      if (o_busy) n_busy++;
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;

    // Reset state.
    @(negedge i_clk);
    checkOutput("reset_q", o_quotient, 32'h0);
    checkOutput("reset_r", o_remainder, 32'h0);
    checkOutput("reset_busy", {31'b0, o_busy}, 32'h0);
    checkOutput("reset_done", {31'b0, o_done}, 32'h0);
    checkOutput("reset_dbz", {31'b0, o_div_by_zero}, 32'h0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // 1: DIVU 100 / 7.
    applyStimulus(32'd100, 32'd7, 1'b0);
    checkOutput("t1_busy_after_accept", {31'b0, o_busy}, 32'h1);
    checkOutput("t1_q_held_while_busy", o_quotient, 32'h0);
    waitDone(edges, busy_cycles);
    checkOutput("t1_latency", edges, 32'd33);
    checkOutput("t1_busy_cycles", busy_cycles, 32'd33);
    checkOutput("t1_busy_in_done", {31'b0, o_busy}, 32'h0);
    checkOutput("t1_q", o_quotient, 32'd14);
    checkOutput("t1_r", o_remainder, 32'd2);
    checkOutput("t1_dbz", {31'b0, o_div_by_zero}, 32'h0);
    @(negedge i_clk);
    checkOutput("t1_done_pulse", {31'b0, o_done}, 32'h0);
    checkOutput("t1_q_hold", o_quotient, 32'd14);

    // 2: signed truncation toward zero.
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
    waitDone(edges, busy_cycles);
    checkOutput("t2a_q", o_quotient, 32'hFFFF_FFFD);
    checkOutput("t2a_r", o_remainder, 32'hFFFF_FFFF);
    @(negedge i_clk);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1);
    waitDone(edges, busy_cycles);
    checkOutput("t2b_q", o_quotient, 32'hFFFF_FFFD);
    checkOutput("t2b_r", o_remainder, 32'd1);
    @(negedge i_clk);

    // 3: most-negative / -1 wraps; same operands unsigned.
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone(edges, busy_cycles);
    checkOutput("t3a_q", o_quotient, 32'h8000_0000);
    checkOutput("t3a_r", o_remainder, 32'h0);
    checkOutput("t3a_dbz", {31'b0, o_div_by_zero}, 32'h0);
    @(negedge i_clk);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    waitDone(edges, busy_cycles);
    checkOutput("t3b_q", o_quotient, 32'h0);
    checkOutput("t3b_r", o_remainder, 32'h8000_0000);
    @(negedge i_clk);

    // 4: divide by zero, unsigned then signed with a negative dividend.
    applyStimulus(32'h0000_1234, 32'h0, 1'b0);
    waitDone(edges, busy_cycles);
    checkOutput("t4a_latency", edges, 32'd1);
    checkOutput("t4a_q", o_quotient, 32'hFFFF_FFFF);
    checkOutput("t4a_r", o_remainder, 32'h0000_1234);
    checkOutput("t4a_dbz", {31'b0, o_div_by_zero}, 32'h1);
    @(negedge i_clk);
    checkOutput("t4a_dbz_held", {31'b0, o_div_by_zero}, 32'h1);
    applyStimulus(32'hFFFF_FFFB, 32'h0, 1'b1);
    waitDone(edges, busy_cycles);
    checkOutput("t4b_q", o_quotient, 32'hFFFF_FFFF);
    checkOutput("t4b_r", o_remainder, 32'hFFFF_FFFB);
    @(negedge i_clk);

    // 5: start pulse during RUN is ignored; start in done cycle is accepted.
    applyStimulus(32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge i_clk);
    applyStimulus(32'd50, 32'd5, 1'b0);
    waitDone(edges, busy_cycles);
    checkOutput("t5a_latency", edges, 32'd27);
    checkOutput("t5a_q", o_quotient, 32'd333);
    checkOutput("t5a_r", o_remainder, 32'd1);
    checkOutput("t5a_dbz_cleared", {31'b0, o_div_by_zero}, 32'h0);
    applyStimulus(32'd9, 32'd4, 1'b0);
    waitDone(edges, busy_cycles);
    checkOutput("t5b_latency", edges, 32'd33);
    checkOutput("t5b_q", o_quotient, 32'd2);
    checkOutput("t5b_r", o_remainder, 32'd1);
    @(negedge i_clk);

    // 6: reset mid-operation aborts with no done.
    applyStimulus(32'd1000, 32'd7, 1'b0);
    repeat (9) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    checkOutput("t6_busy", {31'b0, o_busy}, 32'h0);
    checkOutput("t6_q", o_quotient, 32'h0);
    checkOutput("t6_r", o_remainder, 32'h0);
    checkOutput("t6_done", {31'b0, o_done}, 32'h0);
    @(negedge i_clk);
    i_reset  = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done) saw_done = 1;
    end
    checkOutput("t6_no_done", saw_done, 32'h0);
    applyStimulus(32'd1, 32'd1, 1'b0);
    waitDone(edges, busy_cycles);
    checkOutput("t6_latency", edges, 32'd33);
    checkOutput("t6_q", o_quotient, 32'd1);
    checkOutput("t6_r", o_remainder, 32'd0);

    $display("[TB] directed sequence complete");
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
